// File: rtl/cnn_layer_sequencer.sv
// Run sequencer for the CNN pipeline: loads one image, steps NUM_LAYERS conv/pool pairs, then dense.
// Optional run-cycle counter on perf_cycles_o when SEQ_PERF_CNT_EN is defined.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   S_IDLE  | waiting for start
//   S_LOAD  | counting pixel beats into the line buffers
//   S_CONV  | conv engine enabled for layer layer_idx
//   S_POOL  | pool engine enabled for layer layer_idx
//   S_DENSE | dense engine enabled
//   S_DONE  | one-cycle completion pulse
//   S_ERR   | stage watchdog expired; held until abort or reset
module cnn_layer_sequencer #(
    parameter int IMG_WIDTH      = 150,
    parameter int IMG_HEIGHT     = 150,
    parameter int NUM_LAYERS     = 3,
    parameter int TIMEOUT_CYCLES = 65536,
    localparam int LAYER_W       = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               pixel_in_valid_i,
    input  logic               conv_done_i,
    input  logic               pool_done_i,
    input  logic               dense_done_i,
    output logic               conv_en_o,
    output logic               pool_en_o,
    output logic               dense_en_o,
    output logic [LAYER_W-1:0] layer_idx_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               error_o,
    output logic               global_valid_o,
    output logic [31:0]        perf_cycles_o
);

    localparam int TOTAL_PIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int PIX_W     = $clog2(TOTAL_PIX + 1);
    localparam int WDOG_W    = $clog2(TIMEOUT_CYCLES);

    localparam logic [PIX_W-1:0]   PIX_LAST   = PIX_W'(TOTAL_PIX - 1);
    localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(NUM_LAYERS - 1);
    localparam logic [WDOG_W-1:0]  WDOG_LAST  = WDOG_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CONV,
        S_POOL,
        S_DENSE,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic               wdog_expired;

    logic conv_en_q, pool_en_q, dense_en_q, busy_q, done_q, error_q, global_valid_q;

    assign wdog_expired = (wdog_q == WDOG_LAST);

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        layer_d = layer_q;
        wdog_d  = wdog_q + WDOG_W'(1);

        unique case (state_q)
            S_IDLE: begin
                wdog_d = '0;
                if (start_i) begin
                    state_d = S_LOAD;
                    pix_d   = '0;
                    layer_d = '0;
                end
            end
            S_LOAD: begin
                wdog_d = '0;
                if (pixel_in_valid_i) begin
                    pix_d = pix_q + PIX_W'(1);
                    if (pix_q == PIX_LAST) begin
                        state_d = S_CONV;
                    end
                end
            end
            // A done that coincides with expiry takes precedence over the watchdog.
            S_CONV: begin
                if (conv_done_i) begin
                    state_d = S_POOL;
                    wdog_d  = '0;
                end else if (wdog_expired) begin
                    state_d = S_ERR;
                end
            end
            S_POOL: begin
                if (pool_done_i) begin
                    wdog_d = '0;
                    if (layer_q == LAYER_LAST) begin
                        state_d = S_DENSE;
                    end else begin
                        state_d = S_CONV;
                        layer_d = layer_q + LAYER_W'(1);
                    end
                end else if (wdog_expired) begin
                    state_d = S_ERR;
                end
            end
            S_DENSE: begin
                if (dense_done_i) begin
                    state_d = S_DONE;
                    wdog_d  = '0;
                end else if (wdog_expired) begin
                    state_d = S_ERR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                wdog_d  = '0;
            end
            S_ERR: begin
                wdog_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                wdog_d  = '0;
            end
        endcase

        // Abort in IDLE is a no-op so it cannot disturb a layer_idx left by a finished run.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            pix_d   = '0;
            layer_d = '0;
            wdog_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= S_IDLE;
            pix_q          <= '0;
            layer_q        <= '0;
            wdog_q         <= '0;
            conv_en_q      <= 1'b0;
            pool_en_q      <= 1'b0;
            dense_en_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            global_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pix_q          <= pix_d;
            layer_q        <= layer_d;
            wdog_q         <= wdog_d;
            conv_en_q      <= (state_d == S_CONV);
            pool_en_q      <= (state_d == S_POOL);
            dense_en_q     <= (state_d == S_DENSE);
            busy_q         <= (state_d != S_IDLE);
            done_q         <= (state_d == S_DONE);
            error_q        <= (state_d == S_ERR);
            global_valid_q <= (state_d == S_CONV) || (state_d == S_POOL) || (state_d == S_DENSE);
        end
    end

    assign conv_en_o      = conv_en_q;
    assign pool_en_o      = pool_en_q;
    assign dense_en_o     = dense_en_q;
    assign layer_idx_o    = layer_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign global_valid_o = global_valid_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;
    logic        perf_counting;

    assign perf_counting = !abort_i &&
                           ((state_q == S_LOAD) || (state_q == S_CONV) || (state_q == S_POOL) ||
                            (state_q == S_DENSE) || (state_q == S_DONE));

    // The accepting cycle is the first cycle of the run, so the count restarts at 1.
    always_comb begin
        perf_d = perf_q;
        if ((state_q == S_IDLE) && start_i) begin
            perf_d = 32'd1;
        end else if (perf_counting && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles_o = perf_q;
`else
    assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Scoreboard bench for cnn_layer_sequencer: an open-loop randomized driver predicts output events
// from stage latencies and pixel counts; a monitor pops them whenever the outputs change.
module tb_cnn_layer_sequencer;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int NL = 2;
    localparam int TO = 8;
    localparam int TP = W * H;
`ifdef SEQ_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, abort, pix, cd, pd, dd;
    logic        conv_en, pool_en, dense_en, busy, done, error, global_valid;
    logic        layer_idx;
    logic [31:0] perf_cycles;

    cnn_layer_sequencer #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .NUM_LAYERS(NL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
        .pixel_in_valid_i(pix), .conv_done_i(cd), .pool_done_i(pd), .dense_done_i(dd),
        .conv_en_o(conv_en), .pool_en_o(pool_en), .dense_en_o(dense_en),
        .layer_idx_o(layer_idx), .busy_o(busy), .done_o(done), .error_o(error),
        .global_valid_o(global_valid), .perf_cycles_o(perf_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [7:0] v;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_e;
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         mon_en = 1'b0;
    bit         first = 1'b1;
    logic [7:0] prev;
    logic [7:0] obs;

    assign obs = {conv_en, pool_en, dense_en, layer_idx, busy, done, error, global_valid};

    function automatic logic [7:0] mk(bit c, bit p, bit d, bit l, bit b, bit dn, bit er);
        return {c, p, d, l, b, dn, er, c | p | d};
    endfunction

    always @(negedge clk) begin
        if (mon_en && (first || obs !== prev)) begin
            first = 1'b0;
            prev  = obs;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_change cycle=%0d got=%b", cyc, obs);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.c != cyc || mon_e.v !== obs) begin
                    n_bad++;
                    $display("FAIL out_event got cycle=%0d vec=%b expected cycle=%0d vec=%b",
                             cyc, obs, mon_e.c, mon_e.v);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        start = 0; abort = 0; pix = 0; cd = 0; pd = 0; dd = 0;
    endtask

    task automatic push(int c, logic [7:0] v);
        ev_t e;
        e.c = c;
        e.v = v;
        exp_q.push_back(e);
    endtask

    task automatic chk_perf(string nm, int want);
        logic [31:0] w;
        w = PERF_ON ? 32'(want) : 32'd0;
        n_cmp++;
        if (perf_cycles !== w) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, perf_cycles, w);
        end
    endtask

    // kind: 0 load, 1 conv, 2 pool, 3 dense, 4 done; never drives the matching done or abort
    task automatic noise(bit en, int kind);
        if (en) begin
            pix   = ($urandom_range(0, 3) == 0);
            start = ($urandom_range(0, 5) == 0);
            cd    = (kind != 1) && ($urandom_range(0, 4) == 0);
            pd    = (kind != 2) && ($urandom_range(0, 4) == 0);
            dd    = (kind != 3) && ($urandom_range(0, 4) == 0);
        end
    endtask

    // lat<0: random stage latency; dlat>=0 overrides dense; hang = stage index with no done (-1 none)
    task automatic do_run(int lat, int dlat, bit nz, int hang, bit gaps);
        int s0, e, l_cyc, beats, d;
        s0 = cyc;
        idle_in();
        start = 1;
        if (nz) pix = $urandom_range(0, 1);
        push(s0 + 1, mk(0, 0, 0, 0, 1, 0, 0));
        tick();
        chk_perf("perf_start", 1);
        beats = 0;
        while (beats < TP) begin
            idle_in();
            noise(nz, 0);
            pix = gaps ? ($urandom_range(0, 9) < 6) : 1'b1;
            if (pix) beats++;
            tick();
        end
        for (int i = 0; i <= 2 * NL; i++) begin
            int kind, layer;
            kind  = (i == 2 * NL) ? 3 : ((i % 2 == 0) ? 1 : 2);
            layer = (i == 2 * NL) ? NL - 1 : i / 2;
            e = cyc;
            push(e, mk(kind == 1, kind == 2, kind == 3, bit'(layer), 1, 0, 0));
            if (i == hang) begin
                push(e + TO, mk(0, 0, 0, bit'(layer), 1, 0, 1));
                repeat (TO + 3) begin
                    idle_in();
                    noise(nz, kind);
                    tick();
                end
                repeat (3) begin
                    idle_in();
                    start = 1;
                    tick();
                end
                idle_in();
                abort = 1;
                push(cyc + 1, mk(0, 0, 0, 0, 0, 0, 0));
                tick();
                idle_in();
                chk_perf("perf_err_frozen", e + TO - s0);
                return;
            end
            l_cyc = (kind == 3 && dlat >= 0) ? dlat : ((lat >= 0) ? lat : $urandom_range(0, TO - 1));
            for (int k = 0; k <= l_cyc; k++) begin
                idle_in();
                noise(nz, kind);
                if (k == l_cyc) begin
                    if (kind == 1) cd = 1;
                    else if (kind == 2) pd = 1;
                    else dd = 1;
                end
                tick();
            end
        end
        d = cyc;
        push(d, mk(0, 0, 0, bit'(NL - 1), 1, 1, 0));
        push(d + 1, mk(0, 0, 0, bit'(NL - 1), 0, 0, 0));
        idle_in();
        noise(nz, 4);
        tick();
        idle_in();
        chk_perf("perf_done", d + 1 - s0);
    endtask

    task automatic abort_in_load();
        int s0, a, beats;
        s0 = cyc;
        idle_in();
        start = 1;
        push(s0 + 1, mk(0, 0, 0, 0, 1, 0, 0));
        tick();
        beats = 0;
        while (beats < 10) begin
            idle_in();
            pix = ($urandom_range(0, 9) < 6);
            if (pix) beats++;
            tick();
        end
        idle_in();
        abort = 1;
        a = cyc;
        push(a + 1, mk(0, 0, 0, 0, 0, 0, 0));
        tick();
        idle_in();
        chk_perf("perf_abort_frozen", a - s0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        idle_in();
        reset = 1;
        tick();
        tick();
        push(cyc, mk(0, 0, 0, 0, 0, 0, 0));
        mon_en = 1'b1;
        chk_perf("perf_reset", 0);
        reset = 0;
        tick();
        repeat (4) begin
            idle_in();
            pix = $urandom_range(0, 1);
            cd  = $urandom_range(0, 1);
            pd  = $urandom_range(0, 1);
            dd  = $urandom_range(0, 1);
            tick();
        end
        idle_in();
        do_run(3, -1, 0, -1, 1);
        do_run(0, 0, 0, -1, 0);
        chk_perf("perf_min_run", TP + 2 * NL + 3);
        do_run(0, 0, 0, -1, 0);
        repeat (4) do_run(-1, -1, 1, -1, 1);
        do_run(-1, TO - 1, 1, -1, 1);
        do_run(TO - 1, TO - 1, 0, -1, 1);
        do_run(3, -1, 0, 1, 1);
        tick();
        do_run(-1, -1, 1, $urandom_range(0, 2 * NL), 1);
        abort_in_load();
        do_run(-1, -1, 1, -1, 1);
        repeat (5) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_events got=%0d expected=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
